onchip_memory_copier: RTL and testbench
=======================================

ONCHIP_MEMORY_COPIER -- requirements
Module: onchip_memory_copier

Interface
REQ-001 The block SHALL have a single clock `clk` and a reset `reset` that is synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 11 and sets the master word-address width.
REQ-003 Parameter DATA_W SHALL default to 32 and sets the data width; byteenable width is DATA_W/8.
REQ-004 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- csr_address  in  2  CSR word select
- csr_chipselect  in  1  CSR select
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, combinational from csr_address
- m_address  out  ADDR_W  master word address
- m_read  out  1  master read request
- m_write  out  1  master write request
- m_writedata  out  DATA_W  master write data
- m_byteenable  out  DATA_W/8  byte enables, all ones during transfers
- m_readdata  in  DATA_W  master read data
- m_waitrequest  in  1  slave stall
- m_readdatavalid  in  1  read data valid
- irq  out  1  completion interrupt

Function
REQ-005 The CSR map SHALL be:
- 0 SRC[ADDR_W-1:0]
- 1 DST[ADDR_W-1:0]
- 2 LEN[ADDR_W:0] (words)
- 3 CTRL: bit0 GO (write-1 pulse, reads 0), bit1 BUSY (read-only), bit2 DONE (sticky, write-1-clear), bit3 IRQ_EN (read/write)
REQ-006 Unused CSR bits SHALL read 0.
REQ-007 Writes to SRC, DST and LEN while BUSY=1 SHALL be ignored.
REQ-008 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR_REQ and FINISH.
REQ-009 A GO write in IDLE with LEN>0 SHALL latch the working address, destination and count, set BUSY and clear DONE, and enter RD_REQ on the next cycle.
REQ-010 m_read SHALL assert with the source address in the cycle after the GO write.
REQ-011 RD_REQ SHALL hold m_read and m_address stable while m_waitrequest=1, and go to RD_WAIT when m_waitrequest=0.
REQ-012 RD_WAIT SHALL capture m_readdata on m_readdatavalid=1, then go to WR_REQ.
REQ-013 WR_REQ SHALL hold m_write, m_address=dst and m_writedata stable while m_waitrequest=1.
REQ-014 On write acceptance in WR_REQ, the block SHALL increment src and dst, decrement the count, and go to RD_REQ if count>1, else go to FINISH.
REQ-015 FINISH SHALL last one cycle, clear BUSY, set DONE, and return to IDLE.
REQ-016 A transfer of LEN words SHALL issue LEN reads and LEN writes at ascending addresses.
REQ-017 The minimum cost SHALL be 3 cycles per word, given zero waitrequest and a read latency of 1.
REQ-018 src and dst SHALL wrap modulo 2^ADDR_W without an error flag.
REQ-019 A LEN value above 2^ADDR_W SHALL be saturated to 2^ADDR_W.
REQ-020 A GO write with LEN=0 SHALL set DONE on the next cycle with no bus traffic.
REQ-021 A GO write while BUSY=1 SHALL be ignored.
REQ-022 m_readdatavalid outside RD_WAIT SHALL be ignored.
REQ-023 If a DONE write-1-clear coincides with DONE being set in FINISH, DONE SHALL remain set.
REQ-024 m_read and m_write SHALL never be asserted in the same cycle.
REQ-025 irq SHALL equal DONE AND IRQ_EN, driven from registers.

Reset
REQ-026 On reset, the FSM SHALL enter IDLE, and SRC, DST, LEN, DONE, BUSY and IRQ_EN SHALL be 0.
REQ-027 On reset, m_read, m_write, m_address, m_writedata and irq SHALL be 0, and m_byteenable SHALL be all ones.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer at that clock edge, with no further bus requests, and the in-flight word is discarded.

Structure
REQ-029 Shared package onchip_memory_copier_pkg SHALL hold the FSM state enum, the CSR offsets and the CTRL bit positions.
REQ-030 The CSR decode and registers SHALL live in one sub-module, onchip_memory_copier_csr; the FSM and datapath SHALL be in the top module.

Verification
REQ-031 Basic copy: SRC=0x010, DST=0x400, LEN=4, GO, slave latency 1, no wait -> writes to 0x400..0x403 equal the data at 0x010..0x013; BUSY=0 and DONE=1 twelve cycles after the first m_read.
REQ-032 Waitrequest: waitrequest held high 3 cycles on each request -> address and data stay stable throughout, and the copy is correct.
REQ-033 Wrap-around: SRC=0x7FE, DST=0x000, LEN=4 -> reads at 0x7FE, 0x7FF, 0x000, 0x001.
REQ-034 LEN=0: GO -> DONE=1 the next cycle, m_read and m_write never asserted, irq=1 if IRQ_EN=1.
REQ-035 Reset mid-transfer: reset during WR_REQ of word 2 -> m_write=0 next cycle, all CSRs read 0, and a following LEN=1 copy succeeds.
REQ-036 Collisions: DONE clear coincident with completion -> DONE reads 1; a GO or SRC write while busy -> ignored.

Source files
------------

// File: rtl/onchip_memory_copier_pkg.sv
// Shared definitions for the on-chip memory copier: FSM state encoding,
// CSR word offsets and CTRL register bit positions.
package onchip_memory_copier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    localparam logic [1:0] CSR_SRC  = 2'd0;
    localparam logic [1:0] CSR_DST  = 2'd1;
    localparam logic [1:0] CSR_LEN  = 2'd2;
    localparam logic [1:0] CSR_CTRL = 2'd3;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_IRQ_EN = 3;

endpackage

// File: rtl/onchip_memory_copier_if.sv
// Bus bundle of the copier: the CSR slave port, the memory master port and
// the completion interrupt.
//   master : the copier's view (drives csr_readdata, m_*, irq)
//   slave  : the surrounding system's view (CSR host + memory)
interface onchip_memory_copier_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [1:0]          csr_address;
    logic                csr_chipselect;
    logic                csr_read;
    logic                csr_write;
    logic [31:0]         csr_writedata;
    logic [31:0]         csr_readdata;
    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;
    logic                m_readdatavalid;
    logic                irq;

    modport master (
        input  csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
        output csr_readdata,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata, m_waitrequest, m_readdatavalid,
        output irq
    );

    modport slave (
        output csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
        input  csr_readdata,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata, m_waitrequest, m_readdatavalid,
        input  irq
    );
endinterface

// File: rtl/onchip_memory_copier_csr.sv
// CSR block of the copier: SRC/DST/LEN/CTRL registers and read decode.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   csr_*               CSR slave port (readdata is combinational from address)
//   busy                transfer in progress (from the FSM); locks SRC/DST/LEN
//   done_set, done_clr  completion set / new-transfer clear of DONE
//   src, dst, len       programmed transfer parameters
//   irq_en, done        CTRL flags
//   go_wr               one-cycle pulse: CTRL written with GO=1
module onchip_memory_copier_csr
    import onchip_memory_copier_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    input  logic              busy,
    input  logic              done_set,
    input  logic              done_clr,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [ADDR_W:0]   len,
    output logic              irq_en,
    output logic              done,
    output logic              go_wr
);
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    // Lengths beyond the address space clamp to one full pass over it.
    function automatic logic [ADDR_W:0] sat_len(input logic [31:0] v);
        if (v > 32'(LEN_MAX)) begin
            return LEN_MAX;
        end else begin
            return v[ADDR_W:0];
        end
    endfunction

    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              irq_en_q, irq_en_d, done_q, done_d;
    logic              wr_en;
    logic              unused_read;

    // Reads have no side effects, so the read strobe is not needed.
    assign unused_read = csr_read;
    assign wr_en       = csr_chipselect & csr_write;

    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        go_wr    = 1'b0;
        if (wr_en) begin
            case (csr_address)
                CSR_SRC:  if (!busy) src_d = csr_writedata[ADDR_W-1:0];
                CSR_DST:  if (!busy) dst_d = csr_writedata[ADDR_W-1:0];
                CSR_LEN:  if (!busy) len_d = sat_len(csr_writedata);
                default: begin
                    go_wr    = csr_writedata[CTRL_GO];
                    irq_en_d = csr_writedata[CTRL_IRQ_EN];
                    if (csr_writedata[CTRL_DONE]) done_d = 1'b0;
                end
            endcase
        end
        if (done_clr) done_d = 1'b0;
        // Completion wins over a coincident write-1-clear so it is never lost.
        if (done_set) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            CSR_SRC: csr_readdata[ADDR_W-1:0] = src_q;
            CSR_DST: csr_readdata[ADDR_W-1:0] = dst_q;
            CSR_LEN: csr_readdata[ADDR_W:0]   = len_q;
            default: begin
                csr_readdata[CTRL_BUSY]   = busy;
                csr_readdata[CTRL_DONE]   = done_q;
                csr_readdata[CTRL_IRQ_EN] = irq_en_q;
            end
        endcase
    end

    assign src    = src_q;
    assign dst    = dst_q;
    assign len    = len_q;
    assign irq_en = irq_en_q;
    assign done   = done_q;
endmodule

// File: rtl/onchip_memory_copier.sv
// On-chip memory copier: copies LEN words from SRC to DST over a
// waitrequest/readdatavalid style master port, one read then one write per
// word, addresses ascending and wrapping modulo 2^ADDR_W.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (aborts any transfer)
//   bus    CSR slave port, memory master port and irq (master modport)
module onchip_memory_copier
    import onchip_memory_copier_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input logic                   clk,
    input logic                   reset,
    onchip_memory_copier_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    logic [ADDR_W-1:0] csr_src, csr_dst;
    logic [ADDR_W:0]   csr_len;
    logic              irq_en, done, go_wr;
    logic              start, zero_go, last_accept;

    onchip_memory_copier_csr #(.ADDR_W(ADDR_W)) u_csr (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (bus.csr_address),
        .csr_chipselect (bus.csr_chipselect),
        .csr_read       (bus.csr_read),
        .csr_write      (bus.csr_write),
        .csr_writedata  (bus.csr_writedata),
        .csr_readdata   (bus.csr_readdata),
        .busy           (busy_q),
        .done_set       (last_accept | zero_go),
        .done_clr       (start),
        .src            (csr_src),
        .dst            (csr_dst),
        .len            (csr_len),
        .irq_en         (irq_en),
        .done           (done),
        .go_wr          (go_wr)
    );

    always_comb begin
        start       = go_wr && (state_q == ST_IDLE) && (csr_len != '0);
        zero_go     = go_wr && (state_q == ST_IDLE) && (csr_len == '0);
        last_accept = 1'b0;
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = csr_src;
                    dst_d   = csr_dst;
                    cnt_d   = csr_len;
                    busy_d  = 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (!bus.m_waitrequest) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.m_readdatavalid) begin
                    data_d  = bus.m_readdata;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (!bus.m_waitrequest) begin
                    src_d = src_q + ADDR_ONE;
                    dst_d = dst_q + ADDR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q > CNT_ONE) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        // BUSY/DONE update on entry so FINISH already shows completion.
                        busy_d      = 1'b0;
                        last_accept = 1'b1;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        bus.m_read    = (state_q == ST_RD_REQ);
        bus.m_write   = (state_q == ST_WR_REQ);
        bus.m_address = '0;
        if (state_q == ST_RD_REQ) bus.m_address = src_q;
        if (state_q == ST_WR_REQ) bus.m_address = dst_q;
    end

    assign bus.m_writedata  = data_q;
    assign bus.m_byteenable = '1;
    assign bus.irq          = irq_en & done;
endmodule

// File: tb/tb_onchip_memory_copier.sv
// Self-checking bench for onchip_memory_copier: a memory slave model with
// configurable waitrequest and latency-1 reads, a reference model that
// predicts the read/write sequence of each copy, table-driven CSR and copy
// vectors, randomized copies and hand-written corner-case sequences.
module tb_onchip_memory_copier;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MEM_WORDS = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } csr_vec_t;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [31:0]   len;
        int            wait_n;
        bit            ie;
        int            exp_words;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            exp_cycles;
    } copy_vec_t;

    logic clk, reset;
    onchip_memory_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    onchip_memory_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [MEM_WORDS];
    int            wait_n = 0;
    bit            noise  = 0;
    logic [AW-1:0] rd_log[$], exp_rd[$];
    wr_t           wr_log[$], exp_wr[$];
    bit            cur_ie;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Memory slave: waitrequest for wait_n cycles per request, read data one
    // cycle after acceptance, accepted writes update mem. Nothing is accepted
    // on a clock edge where reset is high.
    initial begin : slave
        logic          pend, acc, stall;
        logic [AW-1:0] pend_addr;
        logic          cur_rd, cur_wr;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_data;
        logic [44:0]   st_sig;
        int            wcnt;
        pend = 0; stall = 0; wcnt = 0; st_sig = '0;
        bus.m_waitrequest = 1'b0; bus.m_readdatavalid = 1'b0; bus.m_readdata = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = mem[pend_addr];
            end else begin
                bus.m_readdatavalid = noise && ($urandom_range(3) == 0);
                bus.m_readdata      = $urandom;
            end
            pend     = 0;
            cur_rd   = bus.m_read;
            cur_wr   = bus.m_write;
            cur_addr = bus.m_address;
            cur_data = bus.m_writedata;
            if (stall)
                check("stall_stable", {cur_rd, cur_wr, cur_addr, cur_wr ? cur_data : 32'h0}, st_sig);
            acc = 0;
            if (cur_rd || cur_wr) begin
                check("rd_wr_exclusive", 64'(cur_rd & cur_wr), 64'd0);
                check("byteenable", 64'(bus.m_byteenable), 64'hF);
                if (wcnt < wait_n) begin
                    bus.m_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    bus.m_waitrequest = 1'b0;
                    wcnt = 0;
                    acc  = 1;
                end
            end else begin
                bus.m_waitrequest = 1'b0;
                wcnt = 0;
            end
            st_sig = {cur_rd, cur_wr, cur_addr, cur_wr ? cur_data : 32'h0};
            @(posedge clk);
            stall = bus.m_waitrequest && !reset && (cur_rd || cur_wr);
            if (reset) wcnt = 0;
            if (acc && !reset) begin
                if (cur_rd) begin
                    pend      = 1;
                    pend_addr = cur_addr;
                    rd_log.push_back(cur_addr);
                end else begin
                    mem[cur_addr] = cur_data;
                    wr_log.push_back('{cur_addr, cur_data});
                end
            end
        end
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address = a; bus.csr_writedata = d;
        bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address = a; bus.csr_read = 1'b1;
        #1;
        d = bus.csr_readdata;
        bus.csr_read = 1'b0;
    endtask

    // Programs a copy, predicts its bus traffic from the memory contents
    // (word i: read src+i, then write that word to dst+i), issues GO and
    // checks the first read request appears the next cycle.
    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [31:0] lw, input int w, input bit ie);
        logic [DW-1:0] snap [MEM_WORDS];
        logic [AW-1:0] as, ad;
        int n;
        wait_n = w; cur_ie = ie;
        rd_log.delete(); wr_log.delete(); exp_rd.delete(); exp_wr.delete();
        n = (lw > 32'(MEM_WORDS)) ? MEM_WORDS : int'(lw);
        snap = mem;
        for (int i = 0; i < n; i++) begin
            as = s + AW'(i);
            ad = d + AW'(i);
            snap[ad] = snap[as];
            exp_rd.push_back(as);
            exp_wr.push_back('{ad, snap[ad]});
        end
        csr_wr(2'd0, 32'(s));
        csr_wr(2'd1, 32'(d));
        csr_wr(2'd2, lw);
        csr_wr(2'd3, {28'h0, ie, 3'b001});
        check("first_read", {bus.m_read, bus.m_address}, {1'b1, s});
    endtask

    task automatic finish_copy(input int exp_cyc, input string nm);
        logic [31:0] r;
        logic        irq_s;
        int n, bad;
        bit ok;
        n = 0; ok = 0; r = '0; irq_s = 0;
        while (n < 20000 && !ok) begin
            @(negedge clk);
            n++;
            csr_rd(2'd3, r);
            irq_s = bus.irq;
            ok = !r[1];
        end
        check({nm, "_cycles"}, 64'(n), 64'(exp_cyc));
        check({nm, "_done"}, 64'(r[2]), 64'd1);
        check({nm, "_irq"}, 64'(irq_s), 64'(cur_ie));
        repeat (2) @(negedge clk);
        bad = -1;
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            if (bad < 0 && rd_log[i] !== exp_rd[i]) bad = i;
        if (bad >= 0) check({nm, "_read_addr"}, 64'(rd_log[bad]), 64'(exp_rd[bad]));
        else          check({nm, "_read_count"}, 64'(rd_log.size()), 64'(exp_rd.size()));
        bad = -1;
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            if (bad < 0 && wr_log[i] !== exp_wr[i]) bad = i;
        if (bad >= 0) check({nm, "_write_addr_data"}, 64'(wr_log[bad]), 64'(exp_wr[bad]));
        else          check({nm, "_write_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    endtask

    initial begin : main
        csr_vec_t    cv[10];
        copy_vec_t   vv[5];
        logic [31:0] r;
        logic [AW-1:0] rs, rdst;
        int rl, rw;

        cv[0] = '{2'd0, 32'hFFFF_FFFF, 32'h7FF};
        cv[1] = '{2'd1, 32'h0000_1234, 32'h234};
        cv[2] = '{2'd2, 32'h0000_0900, 32'h800};
        cv[3] = '{2'd2, 32'h0000_0801, 32'h800};
        cv[4] = '{2'd2, 32'h0000_0800, 32'h800};
        cv[5] = '{2'd2, 32'h0000_07FF, 32'h7FF};
        cv[6] = '{2'd2, 32'hFFFF_FFFF, 32'h800};
        cv[7] = '{2'd3, 32'h0000_0008, 32'h8};
        cv[8] = '{2'd3, 32'h0000_00F0, 32'h0};
        cv[9] = '{2'd0, 32'h0000_05A5, 32'h5A5};

        vv[0] = '{11'h010, 11'h400, 32'd4,      0, 1'b0, 4,    11'h010, 11'h013, 12};
        vv[1] = '{11'h020, 11'h300, 32'd3,      3, 1'b1, 3,    11'h020, 11'h022, 27};
        vv[2] = '{11'h7FE, 11'h000, 32'd4,      0, 1'b1, 4,    11'h7FE, 11'h001, 12};
        vv[3] = '{11'h000, 11'h400, 32'h1000,   0, 1'b0, 2048, 11'h000, 11'h7FF, 6144};
        vv[4] = '{11'h123, 11'h456, 32'd1,      1, 1'b0, 1,    11'h123, 11'h123, 5};

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        reset = 1'b1;
        bus.csr_address = '0; bus.csr_chipselect = 1'b0; bus.csr_read = 1'b0;
        bus.csr_write = 1'b0; bus.csr_writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_bus", {bus.m_read, bus.m_write, bus.m_address, bus.m_writedata, bus.irq},
              {1'b0, 1'b0, 11'h0, 32'h0, 1'b0});
        check("reset_byteenable", 64'(bus.m_byteenable), 64'hF);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), r);
            check($sformatf("reset_csr%0d", a), 64'(r), 64'd0);
        end

        // CSR write/readback table.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            csr_wr(cv[i].a, cv[i].wd);
            csr_rd(cv[i].a, r);
            check($sformatf("csr_vec%0d", i), 64'(r), 64'(cv[i].exp_rd));
        end

        // LEN=0: DONE next cycle, no bus traffic, irq follows IRQ_EN.
        csr_wr(2'd2, 32'd0);
        rd_log.delete(); wr_log.delete();
        csr_wr(2'd3, 32'h9);
        csr_rd(2'd3, r);
        check("len0_ctrl", 64'(r), 64'hC);
        check("len0_irq", 64'(bus.irq), 64'd1);
        repeat (4) @(negedge clk);
        check("len0_no_traffic", 64'(rd_log.size() + wr_log.size()), 64'd0);
        csr_wr(2'd3, 32'h4);
        check("irq_cleared", 64'(bus.irq), 64'd0);

        // Directed copy table.
        for (int i = 0; i < 5; i++) begin
            start_copy(vv[i].src, vv[i].dst, vv[i].len, vv[i].wait_n, vv[i].ie);
            finish_copy(vv[i].exp_cycles, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_words", i), 64'(rd_log.size()), 64'(vv[i].exp_words));
            if (rd_log.size() > 0) begin
                check($sformatf("vec%0d_first", i), 64'(rd_log[0]), 64'(vv[i].exp_first));
                check($sformatf("vec%0d_last", i), 64'(rd_log[$]), 64'(vv[i].exp_last));
            end
            csr_wr(2'd3, 32'h4);
        end

        // Randomized copies with spurious readdatavalid pulses.
        noise = 1;
        for (int k = 0; k < 6; k++) begin
            rs = AW'($urandom); rdst = AW'($urandom);
            rl = $urandom_range(40, 1); rw = $urandom_range(2, 0);
            start_copy(rs, rdst, 32'(rl), rw, 1'($urandom));
            finish_copy(rl * (3 + 2 * rw), $sformatf("rand%0d", k));
        end
        noise = 0;

        // DONE write-1-clear on the same edge completion sets DONE.
        start_copy(11'h050, 11'h060, 32'd1, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("collide_in_wr", 64'(bus.m_write), 64'd1);
        csr_wr(2'd3, 32'h4);
        csr_rd(2'd3, r);
        check("collide_done_kept", 64'(r), 64'h4);
        csr_wr(2'd3, 32'h4);
        csr_rd(2'd3, r);
        check("done_cleared", 64'(r), 64'h0);
        check("collide_writes", 64'(wr_log.size()), 64'd1);

        // SRC write and GO while busy are ignored.
        start_copy(11'h100, 11'h200, 32'd3, 0, 1'b0);
        csr_wr(2'd0, 32'h555);
        csr_wr(2'd3, 32'h1);
        finish_copy(7, "busy_writes");
        csr_rd(2'd0, r);
        check("busy_src_kept", 64'(r), 64'h100);
        repeat (10) @(negedge clk);
        check("busy_go_ignored", 64'(rd_log.size()), 64'd3);

        // Reset during the write of word 2.
        start_copy(11'h300, 11'h310, 32'd4, 0, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_reset_wr2", {bus.m_write, bus.m_address}, {1'b1, 11'h311});
        reset = 1'b1;
        @(negedge clk);
        check("abort_bus", {bus.m_read, bus.m_write}, 2'b00);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), r);
            check($sformatf("abort_csr%0d", a), 64'(r), 64'd0);
        end
        @(negedge clk);
        check("abort_idle", {bus.m_read, bus.m_write}, 2'b00);
        start_copy(11'h040, 11'h041, 32'd1, 0, 1'b1);
        finish_copy(3, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
